// File: rtl/nexus_mult_accum.sv
// Accumulates COUNT products from a MULT9X9 Z stream into an ACC_W-bit sum.
// The sum is presented on a registered valid/ready output.
module nexus_mult_accum #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 24,
    parameter int COUNT  = 4,
    parameter int SIGNED = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PROD_W-1:0] P,
    input  logic              P_VALID,
    output logic              P_READY,
    input  logic              CLR,
    output logic [ACC_W-1:0]  Y,
    output logic              OVF,
    output logic              Y_VALID,
    input  logic              Y_READY
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic             carry;
    logic             add_ovf;
    logic             last;
    logic             take;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            logic sbit;
            assign sbit  = (SIGNED != 0) ? P[PROD_W-1] : 1'b0;
            assign p_ext = {{(ACC_W-PROD_W){sbit}}, P};
        end else begin : g_noext
            assign p_ext = P;
        end
    endgenerate

    assign {carry, sum} = {1'b0, acc} + {1'b0, p_ext};

    // Signed overflow: like-signed operands yielding a result of the other sign.
    always_comb begin
        add_ovf = carry;
        if (SIGNED != 0)
            add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    assign last    = (cnt == LAST);
    // Only the final product of a group can stall, and only on a full, non-draining output.
    assign P_READY = !RST && !CLR && !(last && Y_VALID && !Y_READY);
    assign take    = P_VALID && P_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            Y       <= '0;
            OVF     <= 1'b0;
            Y_VALID <= 1'b0;
        end else begin
            if (take && last) begin
                Y       <= sum;
                OVF     <= ovf_acc | add_ovf;
                Y_VALID <= 1'b1;
            end else if (Y_READY) begin
                Y_VALID <= 1'b0;
            end

            if (CLR || (take && last)) begin
                acc     <= '0;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end else if (take) begin
                acc     <= sum;
                cnt     <= cnt + 1'b1;
                ovf_acc <= ovf_acc | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_nexus_mult_accum.sv
// Directed bench for nexus_mult_accum: three parameterizations share stimulus.
// Expected results are queued at drive time and popped when an output transfers.
module tb_nexus_mult_accum;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [17:0] P = '0;
    logic        P_VALID = 1'b0;
    logic        CLR = 1'b0;
    logic        Y_READY = 1'b1;

    logic        rdy0, rdy1, rdy2;
    logic [23:0] y0, y2;
    logic [17:0] y1;
    logic        ovf0, ovf1, ovf2;
    logic        yv0, yv1, yv2;

    int ncmp = 0;
    int nfail = 0;

    logic [24:0] q0[$];
    logic [24:0] q1[$];
    logic [24:0] q2[$];
    logic        en0 = 1'b0, en12 = 1'b0;
    logic        pr0;

    always #5 CLK = ~CLK;

    nexus_mult_accum #(.PROD_W(18), .ACC_W(24), .COUNT(4), .SIGNED(0)) u0 (
        .CLK(CLK), .RST(RST), .P(P), .P_VALID(P_VALID), .P_READY(rdy0), .CLR(CLR),
        .Y(y0), .OVF(ovf0), .Y_VALID(yv0), .Y_READY(Y_READY));

    nexus_mult_accum #(.PROD_W(18), .ACC_W(18), .COUNT(4), .SIGNED(0)) u1 (
        .CLK(CLK), .RST(RST), .P(P), .P_VALID(P_VALID), .P_READY(rdy1), .CLR(CLR),
        .Y(y1), .OVF(ovf1), .Y_VALID(yv1), .Y_READY(Y_READY));

    nexus_mult_accum #(.PROD_W(18), .ACC_W(24), .COUNT(4), .SIGNED(1)) u2 (
        .CLK(CLK), .RST(RST), .P(P), .P_VALID(P_VALID), .P_READY(rdy2), .CLR(CLR),
        .Y(y2), .OVF(ovf2), .Y_VALID(yv2), .Y_READY(Y_READY));

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output transfers happen on the next edge when valid and ready are both high here.
    task automatic mon();
        logic [24:0] e;
        pr0 = rdy0;
        if (en0 && yv0 && Y_READY) begin
            chk("q0_has_entry", 25'(q0.size() != 0), 25'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("u0_result", {ovf0, y0}, e);
            end
        end
        if (en12 && yv1 && Y_READY) begin
            chk("q1_has_entry", 25'(q1.size() != 0), 25'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("u1_result", {ovf1, 6'd0, y1}, e);
            end
        end
        if (en12 && yv2 && Y_READY) begin
            chk("q2_has_entry", 25'(q2.size() != 0), 25'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("u2_result", {ovf2, y2}, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [17:0] p, output logic acc);
        P = p;
        P_VALID = 1'b1;
        tick();
        acc = pr0;
        P_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        logic a;
        logic all_rdy;

        // Reset state
        tick();
        chk("rst_y", {ovf0, y0}, 25'd0);
        chk("rst_yvalid", 25'(yv0), 25'd0);
        chk("rst_pready_low", 25'(rdy0), 25'd0);
        RST = 1'b0;
        #1;
        chk("pready_after_rst", 25'(rdy0), 25'd1);
        en0 = 1'b1;

        // Basic group
        Y_READY = 1'b1;
        send(18'd1, a); send(18'd2, a); send(18'd3, a);
        q0.push_back({1'b0, 24'd10});
        send(18'd4, a);
        chk("basic_vld_latency", 25'(yv0), 25'd1);
        tick();
        chk("basic_vld_one_cycle", 25'(yv0), 25'd0);

        // Back-to-back groups
        all_rdy = 1'b1;
        for (int i = 100; i < 108; i++) begin
            if (i == 103) q0.push_back({1'b0, 24'd406});
            if (i == 107) q0.push_back({1'b0, 24'd422});
            send(18'(i), a);
            all_rdy &= a;
        end
        chk("b2b_pready_never_drops", 25'(all_rdy), 25'd1);
        tick(); tick();

        // Backpressure
        Y_READY = 1'b0;
        send(18'd1, a); send(18'd2, a); send(18'd3, a);
        q0.push_back({1'b0, 24'd10});
        send(18'd4, a);
        for (int i = 5; i < 8; i++) begin
            send(18'(i), a);
            chk("bp_accept_5_7", 25'(a), 25'd1);
            chk("bp_y_hold", {ovf0, y0}, {1'b0, 24'd10});
        end
        send(18'd8, a);
        chk("bp_stall_8", 25'(a), 25'd0);
        chk("bp_y_hold_stall", {ovf0, y0}, {1'b0, 24'd10});
        Y_READY = 1'b1;
        q0.push_back({1'b0, 24'd26});
        send(18'd8, a);
        chk("bp_accept_8", 25'(a), 25'd1);
        chk("bp_vld_stays", 25'(yv0), 25'd1);
        chk("bp_y_26", {ovf0, y0}, {1'b0, 24'd26});
        tick(); tick();

        // Overflow (unsigned, ACC_W=18) and signed, same stimulus
        en0 = 1'b0;
        do_reset();
        en12 = 1'b1;
        q1.push_back({1'b1, 24'h03FFFC});
        q2.push_back({1'b0, 24'hFFFFFC});
        for (int i = 0; i < 4; i++) send(18'h3FFFF, a);
        q1.push_back({1'b0, 24'd1});
        q2.push_back({1'b0, 24'd1});
        send(18'd0, a); send(18'd0, a); send(18'd0, a); send(18'd1, a);
        tick(); tick();
        chk("q1_drained", 25'(q1.size()), 25'd0);
        chk("q2_drained", 25'(q2.size()), 25'd0);
        en12 = 1'b0;
        do_reset();
        en0 = 1'b1;

        // RST mid-group
        send(18'd9, a); send(18'd9, a);
        RST = 1'b1;
        tick();
        chk("rst_mid_vld_during", 25'(yv0), 25'd0);
        RST = 1'b0;
        #1;
        chk("rst_mid_vld_after", 25'(yv0), 25'd0);
        q0.push_back({1'b0, 24'd20});
        for (int i = 0; i < 4; i++) send(18'd5, a);
        tick(); tick();

        // CLR mid-group
        send(18'd9, a); send(18'd9, a);
        CLR = 1'b1;
        send(18'd9, a);
        chk("clr_blocks_take", 25'(a), 25'd0);
        CLR = 1'b0;
        q0.push_back({1'b0, 24'd20});
        for (int i = 0; i < 4; i++) send(18'd5, a);
        tick(); tick();

        chk("q0_drained", 25'(q0.size()), 25'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
